// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter: shares one memory port between the CPU memory stage and a
// debug/DMA master, with round-robin tie-breaking and a ready-timeout abort.
module data_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, CPU_ACC = 2'd1, DBG_ACC = 2'd2} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q;
  logic [7:0]        wait_q;
  logic              err_q;
  logic              dbg_last_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              dbg_ack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic cpu_req;
  logic in_acc;
  logic timeout;
  logic done;
  logic grant_cpu;

  assign cpu_req   = cpu_read | cpu_write;
  assign in_acc    = (state_q == CPU_ACC) || (state_q == DBG_ACC);
  assign timeout   = in_acc && !mem_ready && (wait_q == WAIT_LAST);
  assign done      = in_acc && (mem_ready || timeout);
  // On a tie the CPU wins only if the debug side was the last one served.
  assign grant_cpu = cpu_req && (!dbg_req || dbg_last_q);

  // Gated by rst_n so every output reads 0 while reset is held.
  assign cpu_stall = rst_n && cpu_req && !((state_q == CPU_ACC) && (mem_ready || timeout));
  assign cpu_rdata = ((state_q == CPU_ACC) && mem_ready && mem_read_q) ? mem_rdata : '0;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      err_q       <= 1'b0;
      dbg_last_q  <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      dbg_ack_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      dbg_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (grant_cpu) begin
            state_q     <= CPU_ACC;
            mem_write_q <= cpu_write;
            mem_read_q  <= !cpu_write;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
          end else if (dbg_req) begin
            state_q     <= DBG_ACC;
            mem_write_q <= dbg_we;
            mem_read_q  <= !dbg_we;
            mem_addr_q  <= dbg_addr;
            mem_wdata_q <= dbg_wdata;
          end
        end
        CPU_ACC, DBG_ACC: begin
          if (done) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            dbg_last_q  <= (state_q == DBG_ACC);
            if (timeout) err_q <= 1'b1;
            if (state_q == DBG_ACC) begin
              dbg_ack_q <= 1'b1;
              if (timeout)         dbg_rdata_q <= '0;
              else if (mem_read_q) dbg_rdata_q <= mem_rdata;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
